// File: rtl/hf_reader_demod_ssp.sv
// hf_reader_demod_ssp - ISO14443-A reader front end: subcarrier edge detector, SSP master, carrier gate.
// Optional gaussian-derivative prefilter enabled by defining HF_PREFILTER_EN.
module hf_reader_demod_ssp #(
  parameter int ADC_W       = 8,
  parameter int WIN_LOG2    = 4,
  parameter int FRAME_LOG2  = 3,
  parameter int RESET_PHASE = 4,
  parameter int THR_W       = 8
) (
  input  logic             ck_1356meg,
  input  logic             nrst,
  input  logic [2:0]       mode,
  input  logic [THR_W-1:0] threshold,
  input  logic [ADC_W-1:0] adc_d,
  input  logic             ssp_dout,
  output logic             ssp_clk,
  output logic             ssp_frame,
  output logic             ssp_din,
  output logic             curbit,
  output logic             pwr_hi
);

  localparam int CW   = WIN_LOG2 + FRAME_LOG2;
  localparam int FB   = 1 << FRAME_LOG2;
  localparam int FW   = ADC_W + 3;
  localparam int CMPW = ((ADC_W > THR_W) ? ADC_W : THR_W) + 4;
  localparam logic [WIN_LOG2-1:0] RP = WIN_LOG2'(RESET_PHASE);

  localparam logic [2:0] M_SNIFF  = 3'b000;
  localparam logic [2:0] M_LISTEN = 3'b011;
  localparam logic [2:0] M_MOD    = 3'b100;
  localparam logic [2:0] M_IDLE   = 3'b111;

  logic [CW-1:0]         cnt;
  logic [WIN_LOG2-1:0]   ph;
  logic [FRAME_LOG2-1:0] bitidx;
  logic [2:0]            mode_q;
  logic                  mod_q;
  logic                  car_en;
  logic                  car_en_next;
  logic signed [FW-1:0]  f;
  logic signed [FW-1:0]  fmax;
  logic signed [FW-1:0]  fmin;
  logic signed [CMPW-1:0] fmax_e;
  logic signed [CMPW-1:0] fmin_e;
  logic signed [CMPW-1:0] thr_e;
  logic                  det;
  logic                  shift_bit;
  logic [FB-1:0]         sh;
  logic [FB-1:0]         sh_next;
  logic [FB-1:0]         tx_word;
  logic [FB-1:0]         tx_next;

  assign ph     = cnt[WIN_LOG2-1:0];
  assign bitidx = cnt[CW-1:WIN_LOG2];

`ifdef HF_PREFILTER_EN
  logic [ADC_W-1:0] x1, x2, x3, x4;
  logic signed [FW-1:0] f_old, f_new;

  assign f_old = $signed({2'b00, x4, 1'b0}) + $signed({3'b000, x3});
  assign f_new = $signed({2'b00, adc_d, 1'b0}) + $signed({3'b000, x1});
  assign f     = f_old - f_new;

  always_ff @(negedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      x1 <= '0;
      x2 <= '0;
      x3 <= '0;
      x4 <= '0;
    end else begin
      x1 <= adc_d;
      x2 <= x1;
      x3 <= x2;
      x4 <= x3;
    end
  end
`else
  logic [ADC_W-1:0] x1;

  // Falling sample gives a positive difference.
  assign f = $signed({3'b000, x1}) - $signed({3'b000, adc_d});

  always_ff @(negedge ck_1356meg or negedge nrst) begin
    if (!nrst) x1 <= '0;
    else       x1 <= adc_d;
  end
`endif

  assign fmax_e = {{(CMPW-FW){fmax[FW-1]}}, fmax};
  assign fmin_e = {{(CMPW-FW){fmin[FW-1]}}, fmin};
  assign thr_e  = $signed({{(CMPW-THR_W){1'b0}}, threshold});
  assign det    = (fmax_e > thr_e) && (fmin_e < -thr_e);

  assign shift_bit = curbit && ((mode_q == M_SNIFF) || (mode_q == M_LISTEN));
  assign sh_next   = {sh[FB-2:0], shift_bit};
  // The word completing at the boundary is the one shifted on that same edge.
  assign tx_next   = (cnt == '0) ? sh_next : tx_word;

  always_comb begin
    car_en_next = 1'b0;
    case (mode_q)
      M_MOD:    car_en_next = ~mod_q;
      M_LISTEN: car_en_next = 1'b1;
      default:  car_en_next = 1'b0;
    endcase
  end

  always_ff @(negedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      cnt       <= '0;
      mode_q    <= M_IDLE;
      mod_q     <= 1'b0;
      car_en    <= 1'b0;
      fmax      <= '0;
      fmin      <= '0;
      curbit    <= 1'b0;
      sh        <= '0;
      tx_word   <= '0;
      ssp_clk   <= 1'b0;
      ssp_frame <= 1'b0;
      ssp_din   <= 1'b0;
    end else begin
      cnt    <= cnt + 1'b1;
      mod_q  <= ssp_dout;
      car_en <= car_en_next;
      if (cnt == '0) begin
        mode_q  <= mode;
        tx_word <= sh_next;
      end
      // fmax/fmin never leave their sides of zero, so one compare covers the sign test.
      if (ph == RP) begin
        curbit <= det;
        fmax   <= '0;
        fmin   <= '0;
      end else begin
        if (f > fmax) fmax <= f;
        if (f < fmin) fmin <= f;
      end
      if (ph == '0) begin
        sh      <= sh_next;
        ssp_din <= tx_next[~bitidx];
      end
      ssp_clk   <= ~ph[WIN_LOG2-1];
      ssp_frame <= (bitidx == '0);
    end
  end

  // Carrier gate: car_en only moves on the falling edge, so the high phase is clean.
  assign pwr_hi = ck_1356meg & car_en;

endmodule
